instruction_fetch_stage: RTL and testbench

IF stage of the pipelined MIPS core. Owns the program counter, drives the program-memory address, and registers the returned instruction into the IF/ID pipeline register. Handles hazard-unit stalls, branch/jump redirects, flushes and out-of-range fetch detection. It sits directly upstream of the combinational program ROM and feeds the ID stage.

---
 rtl/instruction_fetch_stage.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: program counter, ROM address and IF/ID pipeline register
//
// Purpose:
//   Owns the PC, presents it to the combinational program ROM and captures the
//   returned word into the IF/ID register. Handles hazard stalls, branch/jump
//   redirects, flushes and detection of fetches outside program memory.
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   reset            synchronous active-high reset, overrides everything
//   Stall            freeze PC and IF/ID
//   Flush            replace the instruction entering IF/ID with a bubble
//   Redirect         load RedirectTarget (word aligned) into the PC
//   RedirectTarget   byte address of the branch/jump target
//   Instruction_i    ROM word for PC_o, valid in the same cycle
//   PC_o             current PC, drives the ROM address
//   IFID_Instruction registered instruction for ID
//   IFID_PC          registered PC of that instruction
//   IFID_PCPlus4     registered PC+4 of that instruction
//   IFID_Valid       1 = real instruction, 0 = bubble
//   FetchFault       sticky out-of-range fetch flag, cleared only by reset

module instruction_fetch_stage #(
   parameter int                     DATA_WIDTH   = 32,
   parameter int                     MEMORY_DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_PC     = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0]  NOP_WORD     = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  Redirect,
   input  logic [DATA_WIDTH-1:0] RedirectTarget,
   input  logic [DATA_WIDTH-1:0] Instruction_i,
   output logic [DATA_WIDTH-1:0] PC_o,
   output logic [DATA_WIDTH-1:0] IFID_Instruction,
   output logic [DATA_WIDTH-1:0] IFID_PC,
   output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
   output logic                  IFID_Valid,
   output logic                  FetchFault
);

   localparam logic [DATA_WIDTH-3:0] DEPTH_WORDS = (DATA_WIDTH-2)'(MEMORY_DEPTH);
   localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] pc_q,    pc_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] ifpc_q,  ifpc_d;
   logic [DATA_WIDTH-1:0] ifp4_q,  ifp4_d;
   logic                  valid_q, valid_d;
   logic                  fault_q, fault_d;

   logic [DATA_WIDTH-1:0] pc_plus4;
   logic                  in_range;

   assign pc_plus4 = pc_q + PC_STEP;
   assign in_range = (pc_q[DATA_WIDTH-1:2] < DEPTH_WORDS);

   // PC next state. The fetch halts while the current PC is outside program
   // memory, so the PC freezes on the offending address; a redirect is the
   // only way out short of reset. Wrap at 2^DATA_WIDTH is silent.
   always_comb begin
      pc_d = pc_plus4;
      if (Redirect) begin
         pc_d = {RedirectTarget[DATA_WIDTH-1:2], 2'b00};
      end else if (Stall || !in_range) begin
         pc_d = pc_q;
      end
   end

   // IF/ID next state. Flush/Redirect take priority over Stall so a bubble is
   // always inserted when a squash is requested. The PC fields still capture
   // the current PC on a bubble purely as a debug aid.
   always_comb begin
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      ifp4_d  = ifp4_q;
      valid_d = valid_q;
      fault_d = fault_q;
      if (Flush || Redirect) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
         ifpc_d  = pc_q;
         ifp4_d  = pc_plus4;
      end else if (Stall) begin
         // hold every IF/ID field
      end else if (!in_range) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
         ifpc_d  = pc_q;
         ifp4_d  = pc_plus4;
         fault_d = 1'b1;
      end else begin
         instr_d = Instruction_i;
         valid_d = 1'b1;
         ifpc_d  = pc_q;
         ifp4_d  = pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_WORD;
         ifpc_q  <= '0;
         ifp4_q  <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         ifp4_q  <= ifp4_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign PC_o             = pc_q;
   assign IFID_Instruction = instr_q;
   assign IFID_PC          = ifpc_q;
   assign IFID_PCPlus4     = ifp4_q;
   assign IFID_Valid       = valid_q;
   assign FetchFault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - self-checking bench for instruction_fetch_stage

module tb_instruction_fetch_stage;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        reset, Stall, Flush, Redirect;
   logic [31:0] RedirectTarget, Instruction_i;
   logic [31:0] PC_o, IFID_Instruction, IFID_PC, IFID_PCPlus4;
   logic        IFID_Valid, FetchFault;

   logic [31:0] rom [0:DEPTH-1];

   int n_pass  = 0;
   int n_total = 0;

   // reference state
   logic [31:0] m_pc, m_inst, m_ipc, m_ip4;
   logic        m_valid, m_fault;

   instruction_fetch_stage #(
      .DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH),
      .RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)
   ) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
      .Redirect(Redirect), .RedirectTarget(RedirectTarget),
      .Instruction_i(Instruction_i), .PC_o(PC_o),
      .IFID_Instruction(IFID_Instruction), .IFID_PC(IFID_PC),
      .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
      .FetchFault(FetchFault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      if ((addr / 4) < DEPTH) return rom[addr / 4];
      return 32'hDEAD_BEEF;
   endfunction

   always_comb Instruction_i = rom_word(PC_o);

   task automatic load_counting_rom();
      for (int k = 0; k < DEPTH; k++) rom[k] = 32'h1000_0000 + k;
   endtask

   // One clock: apply inputs, advance the reference at the edge, settle.
   task automatic step(input logic r, input logic st, input logic fl,
                       input logic rd, input logic [31:0] tgt);
      logic [31:0] pc0;
      logic        oob;
      reset = r; Stall = st; Flush = fl; Redirect = rd; RedirectTarget = tgt;
      @(posedge clk);
      pc0 = m_pc;
      oob = (pc0 / 4) >= DEPTH;
      if (r) begin
         m_pc = 0; m_inst = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0; m_fault = 0;
      end else begin
         if (rd)              m_pc = tgt & ~32'd3;
         else if (!(st || oob)) m_pc = pc0 + 4;
         if (fl || rd) begin
            m_inst = 0; m_valid = 0; m_ipc = pc0; m_ip4 = pc0 + 4;
         end else if (!st) begin
            if (oob) begin
               m_inst = 0; m_valid = 0; m_ipc = pc0; m_ip4 = pc0 + 4; m_fault = 1;
            end else begin
               m_inst = rom_word(pc0); m_valid = 1; m_ipc = pc0; m_ip4 = pc0 + 4;
            end
         end
      end
      #1;
      reset = 0; Stall = 0; Flush = 0; Redirect = 0; RedirectTarget = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      load_counting_rom();
      step(1, 1, 1, 1, 32'h40);
      n_total++; if (PC_o !== 32'h0) $display("FAIL reset_pc got %h exp %h", PC_o, 32'h0); else n_pass++;
      n_total++; if (IFID_Instruction !== 32'h0) $display("FAIL reset_instr got %h exp %h", IFID_Instruction, 32'h0); else n_pass++;
      n_total++; if ({IFID_PC, IFID_PCPlus4} !== 64'h0) $display("FAIL reset_ifid_pc got %h/%h exp 0/0", IFID_PC, IFID_PCPlus4); else n_pass++;
      n_total++; if ({IFID_Valid, FetchFault} !== 2'b00) $display("FAIL reset_flags got %b%b exp 00", IFID_Valid, FetchFault); else n_pass++;
   endtask

   task automatic test_free_run();
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         step(0, 0, 0, 0, 0);
         n_total++; if (PC_o !== 32'(4 * (k + 1))) $display("FAIL run_pc k=%0d got %h exp %h", k, PC_o, 4 * (k + 1)); else n_pass++;
         n_total++; if (IFID_Instruction !== 32'h1000_0000 + k || IFID_Valid !== 1'b1)
            $display("FAIL run_instr k=%0d got %h/%b exp %h/1", k, IFID_Instruction, IFID_Valid, 32'h1000_0000 + k); else n_pass++;
         n_total++; if (IFID_PC !== 32'(4 * k) || IFID_PCPlus4 !== 32'(4 * k + 4))
            $display("FAIL run_ifid_pc k=%0d got %h/%h exp %h/%h", k, IFID_PC, IFID_PCPlus4, 4 * k, 4 * k + 4); else n_pass++;
      end
   endtask

   task automatic test_stall();
      step(1, 0, 0, 0, 0);
      run(3);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0);
         n_total++; if (PC_o !== 32'h0C || IFID_Instruction !== 32'h1000_0002)
            $display("FAIL stall_hold i=%0d got %h/%h exp 0000000c/10000002", i, PC_o, IFID_Instruction); else n_pass++;
      end
      step(0, 0, 0, 0, 0);
      n_total++; if (IFID_Instruction !== 32'h1000_0003 || PC_o !== 32'h10)
         $display("FAIL stall_resume got %h/%h exp 10000003/00000010", IFID_Instruction, PC_o); else n_pass++;
   endtask

   task automatic test_redirect_stall();
      step(1, 0, 0, 0, 0);
      run(4);
      step(0, 1, 0, 1, 32'h0000_0016);
      n_total++; if (PC_o !== 32'h14) $display("FAIL redir_pc got %h exp %h", PC_o, 32'h14); else n_pass++;
      n_total++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0)
         $display("FAIL redir_bubble got %b/%h exp 0/00000000", IFID_Valid, IFID_Instruction); else n_pass++;
      step(0, 0, 0, 0, 0);
      n_total++; if (IFID_PC !== 32'h14 || IFID_Instruction !== 32'h1000_0005 || IFID_Valid !== 1'b1)
         $display("FAIL redir_target got %h/%h/%b exp 00000014/10000005/1", IFID_PC, IFID_Instruction, IFID_Valid); else n_pass++;
   endtask

   task automatic test_flush();
      step(1, 0, 0, 0, 0);
      run(2);
      step(0, 0, 1, 0, 0);
      n_total++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0)
         $display("FAIL flush_bubble got %b/%h exp 0/00000000", IFID_Valid, IFID_Instruction); else n_pass++;
      n_total++; if (PC_o !== 32'h0C) $display("FAIL flush_pc got %h exp %h", PC_o, 32'h0C); else n_pass++;
   endtask

   task automatic test_fetch_fault();
      step(1, 0, 0, 0, 0);
      run(32);
      n_total++; if (PC_o !== 32'h80 || FetchFault !== 1'b0 || IFID_Valid !== 1'b1)
         $display("FAIL fault_edge got %h/%b/%b exp 00000080/0/1", PC_o, FetchFault, IFID_Valid); else n_pass++;
      run(2);
      n_total++; if (PC_o !== 32'h80 || FetchFault !== 1'b1 || IFID_Valid !== 1'b0)
         $display("FAIL fault_set got %h/%b/%b exp 00000080/1/0", PC_o, FetchFault, IFID_Valid); else n_pass++;
      step(0, 0, 0, 1, 32'h04);
      step(0, 0, 0, 0, 0);
      n_total++; if (IFID_Valid !== 1'b1 || IFID_PC !== 32'h04 || IFID_Instruction !== 32'h1000_0001 || FetchFault !== 1'b1)
         $display("FAIL fault_resume got %b/%h/%h/%b exp 1/00000004/10000001/1", IFID_Valid, IFID_PC, IFID_Instruction, FetchFault); else n_pass++;
      step(1, 0, 0, 0, 0);
      n_total++; if (FetchFault !== 1'b0) $display("FAIL fault_clear got %b exp 0", FetchFault); else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      run(5);
      step(1, 1, 0, 1, 32'h20);
      n_total++; if (PC_o !== 32'h0 || IFID_Instruction !== 32'h0 || IFID_PC !== 32'h0 || IFID_PCPlus4 !== 32'h0 || IFID_Valid !== 1'b0)
         $display("FAIL midrun_reset got %h/%h/%h/%h/%b exp all 0", PC_o, IFID_Instruction, IFID_PC, IFID_PCPlus4, IFID_Valid); else n_pass++;
   endtask

   task automatic test_random();
      int errs;
      for (int k = 0; k < DEPTH; k++) rom[k] = $urandom;
      step(1, 0, 0, 0, 0);
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, 32'($urandom_range(0, 40) * 4 + $urandom_range(0, 3)));
         n_total++;
         if (PC_o !== m_pc || IFID_Instruction !== m_inst || IFID_Valid !== m_valid || FetchFault !== m_fault ||
             (m_valid && (IFID_PC !== m_ipc || IFID_PCPlus4 !== m_ip4))) begin
            if (errs < 10)
               $display("FAIL random i=%0d got pc=%h ins=%h v=%b f=%b ipc=%h exp pc=%h ins=%h v=%b f=%b ipc=%h",
                        i, PC_o, IFID_Instruction, IFID_Valid, FetchFault, IFID_PC, m_pc, m_inst, m_valid, m_fault, m_ipc);
            errs++;
         end else n_pass++;
      end
   endtask

   initial begin
      reset = 1; Stall = 0; Flush = 0; Redirect = 0; RedirectTarget = 0;
      m_pc = 0; m_inst = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0; m_fault = 0;
      load_counting_rom();
      @(negedge clk);
      test_reset();
      test_free_run();
      test_stall();
      test_redirect_stall();
      test_flush();
      test_fetch_fault();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
